// File: rtl/data_memory_arbiter_if.sv
// Bus between the two core memory stages, the arbiter and the shared data_memory pins.
// master = cores plus memory side, slave = data_memory_arbiter.
interface data_memory_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_0;
    logic             req_1;
    logic             we_0;
    logic             we_1;
    logic [WIDTH-1:0] addr_0;
    logic [WIDTH-1:0] addr_1;
    logic [WIDTH-1:0] wdata_0;
    logic [WIDTH-1:0] wdata_1;
    logic             ack_0;
    logic             ack_1;
    logic [WIDTH-1:0] rdata_0;
    logic [WIDTH-1:0] rdata_1;
    logic             mem_write_enable;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
        output ack_0, ack_1, rdata_0, rdata_1, mem_write_enable, mem_address, mem_data_in
    );

    modport master (
        output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_data_out,
        input  ack_0, ack_1, rdata_0, rdata_1, mem_write_enable, mem_address, mem_data_in
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-core arbiter/sequencer for the single-port data_memory: IDLE -> ACCESS -> RESPOND.
// Define DATA_MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise core 0 has fixed priority.
module data_memory_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    data_memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    typedef struct packed {
        logic             id;
        logic             we;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } txn_t;

    state_t           state_q;
    txn_t             txn_q;
    logic             ack_0_q;
    logic             ack_1_q;
    logic [WIDTH-1:0] rdata_0_q;
    logic [WIDTH-1:0] rdata_1_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             grant_1_c;
    txn_t             win_c;

`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
    logic prio_q;  // 1 = core 1 preferred on a tie

    always_comb begin
        grant_1_c = bus.req_1 & (~bus.req_0 | prio_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (state_q == IDLE && (bus.req_0 || bus.req_1)) begin
            prio_q <= ~grant_1_c;
        end
    end
`else
    always_comb begin
        grant_1_c = bus.req_1 & ~bus.req_0;
    end
`endif

    // Request payload of the winning core, used only when some req is high in IDLE
    always_comb begin
        win_c.id    = grant_1_c;
        win_c.we    = grant_1_c ? bus.we_1    : bus.we_0;
        win_c.addr  = grant_1_c ? bus.addr_1  : bus.addr_0;
        win_c.wdata = grant_1_c ? bus.wdata_1 : bus.wdata_0;
    end

    // Memory pins are registered so they are non-zero only during ACCESS and clear on reset at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            ack_0_q     <= 1'b0;
            ack_1_q     <= 1'b0;
            rdata_0_q   <= '0;
            rdata_1_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ack_0_q <= 1'b0;
            ack_1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_0 || bus.req_1) begin
                        txn_q       <= win_c;
                        mem_we_q    <= win_c.we;
                        mem_addr_q  <= win_c.addr;
                        mem_wdata_q <= win_c.wdata;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    if (!txn_q.we) begin
                        if (txn_q.id) rdata_1_q <= bus.mem_data_out;
                        else          rdata_0_q <= bus.mem_data_out;
                    end
                    if (txn_q.id) ack_1_q <= 1'b1;
                    else          ack_0_q <= 1'b1;
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_0            = ack_0_q;
    assign bus.ack_1            = ack_1_q;
    assign bus.rdata_0          = rdata_0_q;
    assign bus.rdata_1          = rdata_1_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_data_in      = mem_wdata_q;
endmodule
